// File: rtl/smooth_line_capture_pkg.sv
// Shared definitions for the smoothed-line capture buffer: bank states,
// pixel width and default geometry.
package smooth_line_capture_pkg;

  localparam int PIX_W      = 8;
  localparam int LINE_W_DEF = 64;
  localparam int WARMUP_DEF = 3;

  typedef enum logic [1:0] {
    BANK_EMPTY   = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_FULL    = 2'd2
  } bank_st_e;

endpackage

// File: rtl/smooth_line_capture_line_bank_ram.sv
// One line bank: simple dual-port RAM with a registered, enable-gated read
// port. The read register holds its value when re_i is low.
module line_bank_ram
  import smooth_line_capture_pkg::*;
#(
  parameter int DEPTH = LINE_W_DEF,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [PIX_W-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [PIX_W-1:0] rdata_o
);

  logic [PIX_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/smooth_line_capture.sv
// Captures qualified smoothing-filter samples into ping-pong line banks and
// drains full lines through a valid/ready pixel stream.
module smooth_line_capture
  import smooth_line_capture_pkg::*;
#(
  parameter int LINE_W = LINE_W_DEF,
  parameter int WARMUP = WARMUP_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enb,
  input  logic [PIX_W-1:0] smoothed_in,
  input  logic             line_start,
  output logic [PIX_W-1:0] pix_out,
  output logic             pix_valid,
  input  logic             pix_ready,
  output logic             line_last,
  output logic             overflow
);

  localparam int CW = $clog2(LINE_W);
  localparam int WW = (WARMUP < 1) ? 1 : $clog2(WARMUP + 1);
  localparam logic [CW-1:0] COL_LAST = CW'(LINE_W - 1);
  localparam logic [WW-1:0] WARM_MAX = WW'(WARMUP);

  logic             enb_q;
  logic [WW-1:0]    warm_q, warm_d;
  logic [CW-1:0]    wr_col_q, wr_col_d;
  logic             wr_bank_q, wr_bank_d;
  logic             ovf_q, ovf_d;
  bank_st_e         st_q [2];
  bank_st_e         st_d [2];

  logic [CW-1:0]    iss_col_q;
  logic             iss_bank_q;
  logic             rd_bank_q;
  logic             s1_vld_q, s1_last_q, s1_bank_q;
  logic [PIX_W-1:0] pix_q;
  logic             pv_q, ll_q;

  logic             wr_en, issue, out_load, xfer;
  logic [1:0]       we_b, re_b;
  logic [PIX_W-1:0] rdata0, rdata1, s1_data;

  always_comb begin
    warm_d    = warm_q;
    wr_col_d  = wr_col_q;
    wr_bank_d = wr_bank_q;
    ovf_d     = ovf_q;
    st_d      = st_q;
    wr_en     = 1'b0;
    // line_start beats a coincident sample; the FULL check sees registered state only
    if (line_start) begin
      warm_d   = '0;
      wr_col_d = '0;
      if (st_q[wr_bank_q] == BANK_FILLING) st_d[wr_bank_q] = BANK_EMPTY;
    end else if (enb_q) begin
      if (warm_q < WARM_MAX) begin
        warm_d = warm_q + 1'b1;
      end else if (st_q[wr_bank_q] == BANK_FULL) begin
        ovf_d = 1'b1;
      end else begin
        wr_en = 1'b1;
        if (wr_col_q == COL_LAST) begin
          st_d[wr_bank_q] = BANK_FULL;
          wr_col_d        = '0;
          wr_bank_d       = ~wr_bank_q;
        end else begin
          st_d[wr_bank_q] = BANK_FILLING;
          wr_col_d        = wr_col_q + 1'b1;
        end
      end
    end

    // Reads are issued ahead of the release pointer so consecutive lines stream without bubbles
    out_load = s1_vld_q && (!pv_q || pix_ready);
    xfer     = pv_q && pix_ready;
    issue    = (st_q[iss_bank_q] == BANK_FULL) && (!s1_vld_q || out_load);
    if (xfer && ll_q) st_d[rd_bank_q] = BANK_EMPTY;
  end

  assign we_b    = {wr_en && wr_bank_q, wr_en && !wr_bank_q};
  assign re_b    = {issue && iss_bank_q, issue && !iss_bank_q};
  assign s1_data = s1_bank_q ? rdata1 : rdata0;

  line_bank_ram #(.DEPTH(LINE_W)) u_bank0 (
    .clk     (clk),
    .we_i    (we_b[0]),
    .waddr_i (wr_col_q),
    .wdata_i (smoothed_in),
    .re_i    (re_b[0]),
    .raddr_i (iss_col_q),
    .rdata_o (rdata0)
  );

  line_bank_ram #(.DEPTH(LINE_W)) u_bank1 (
    .clk     (clk),
    .we_i    (we_b[1]),
    .waddr_i (wr_col_q),
    .wdata_i (smoothed_in),
    .re_i    (re_b[1]),
    .raddr_i (iss_col_q),
    .rdata_o (rdata1)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      enb_q      <= 1'b0;
      warm_q     <= '0;
      wr_col_q   <= '0;
      wr_bank_q  <= 1'b0;
      ovf_q      <= 1'b0;
      st_q[0]    <= BANK_EMPTY;
      st_q[1]    <= BANK_EMPTY;
      iss_col_q  <= '0;
      iss_bank_q <= 1'b0;
      rd_bank_q  <= 1'b0;
      s1_vld_q   <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_bank_q  <= 1'b0;
      pix_q      <= '0;
      pv_q       <= 1'b0;
      ll_q       <= 1'b0;
    end else begin
      enb_q     <= enb;
      warm_q    <= warm_d;
      wr_col_q  <= wr_col_d;
      wr_bank_q <= wr_bank_d;
      ovf_q     <= ovf_d;
      st_q      <= st_d;
      if (issue) begin
        s1_vld_q  <= 1'b1;
        s1_bank_q <= iss_bank_q;
        s1_last_q <= (iss_col_q == COL_LAST);
        if (iss_col_q == COL_LAST) begin
          iss_col_q  <= '0;
          iss_bank_q <= ~iss_bank_q;
        end else begin
          iss_col_q <= iss_col_q + 1'b1;
        end
      end else if (out_load) begin
        s1_vld_q <= 1'b0;
      end
      if (out_load) begin
        pix_q <= s1_data;
        ll_q  <= s1_last_q;
        pv_q  <= 1'b1;
      end else if (xfer) begin
        pv_q <= 1'b0;
      end
      if (xfer && ll_q) rd_bank_q <= ~rd_bank_q;
    end
  end

  assign pix_out   = pix_q;
  assign pix_valid = pv_q;
  assign line_last = ll_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_smooth_line_capture.sv
// Scoreboard bench for smooth_line_capture with LINE_W=8, WARMUP=3.
module tb_smooth_line_capture;

  localparam int LW = 8;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enb = 1'b0;
  logic       line_start = 1'b0;
  logic       pix_ready = 1'b0;
  logic [7:0] smoothed_in = 8'd0;
  logic [7:0] pix_out;
  logic       pix_valid, line_last, overflow;

  exp_t       q[$];
  int         checks = 0;
  int         failures = 0;
  int         xfers = 0;
  logic       stalled = 1'b0;
  logic [7:0] st_pix = 8'd0;
  logic       st_last = 1'b0;

  always #5 clk = ~clk;

  smooth_line_capture #(.LINE_W(LW), .WARMUP(3)) dut (
    .clk         (clk),
    .reset       (reset),
    .enb         (enb),
    .smoothed_in (smoothed_in),
    .line_start  (line_start),
    .pix_out     (pix_out),
    .pix_valid   (pix_valid),
    .pix_ready   (pix_ready),
    .line_last   (line_last),
    .overflow    (overflow)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic push_line(input int start, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.d = 8'(start + i);
      e.l = (i == n - 1);
      q.push_back(e);
    end
  endtask

  // Sample k is presented on smoothed_in in the cycle after its enb; ls_idx
  // pulses line_start in the same cycle as that sample.
  task automatic feed(input int start, input int n, input int ls_idx);
    for (int i = 0; i <= n; i++) begin
      @(posedge clk); #1;
      enb = (i < n);
      if (i > 0) smoothed_in = 8'(start + i - 1);
      line_start = (i > 0) && (i - 1 == ls_idx);
    end
    @(posedge clk); #1;
    line_start = 1'b0;
  endtask

  task automatic pulse_ls();
    line_start = 1'b1;
    @(posedge clk); #1;
    line_start = 1'b0;
  endtask

  task automatic check_latency(input string tag);
    @(negedge clk);
    chk({tag, "_pv_w0"}, pix_valid, 0);
    @(negedge clk);
    chk({tag, "_pv_w1"}, pix_valid, 0);
    @(negedge clk);
    chk({tag, "_pv_w2"}, pix_valid, 1);
  endtask

  task automatic wait_empty(input int budget);
    int n = 0;
    while (q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk("drain_done", q.size(), 0);
  endtask

  task automatic wait_xfers(input int target, input int budget);
    int n = 0;
    while (xfers < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("xfer_wait", (xfers >= target), 1);
  endtask

  // Monitor: pops the scoreboard on every transfer and checks stall stability
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          chk("stall_valid", pix_valid, 1);
          chk("stall_pix", pix_out, st_pix);
          chk("stall_last", line_last, st_last);
        end
        if (pix_valid && pix_ready) begin
          xfers++;
          stalled = 1'b0;
          if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL extra_pixel actual=%0d required=none", pix_out);
          end else begin
            e = q.pop_front();
            chk("pix", pix_out, e.d);
            chk("last", line_last, e.l);
          end
        end else if (pix_valid) begin
          stalled = 1'b1;
          st_pix  = pix_out;
          st_last = line_last;
        end else begin
          stalled = 1'b0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int base;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", pix_valid, 0);
    chk("rst_pix", pix_out, 0);
    chk("rst_last", line_last, 0);
    chk("rst_ovf", overflow, 0);
    reset = 1'b1;
    pix_ready = 1'b1;
    @(posedge clk); #1;

    // Basic line: 0..2 warm-up, 3..10 captured
    pulse_ls();
    push_line(3, LW);
    feed(0, 11, -1);
    check_latency("t1");
    wait_empty(100);
    chk("t1_ovf", overflow, 0);

    // Three lines while stalled: third line dropped
    pix_ready = 1'b0;
    pulse_ls();
    push_line(20, LW);
    push_line(28, LW);
    feed(17, 27, -1);
    repeat (4) @(posedge clk);
    #1;
    chk("t2_ovf", overflow, 1);
    chk("t2_held_valid", pix_valid, 1);
    chk("t2_held_pix", pix_out, 20);
    base = xfers;
    pix_ready = 1'b1;
    repeat (16) @(negedge clk);
    chk("t2_burst", xfers - base, 16);
    @(negedge clk);
    chk("t2_burst_end", pix_valid, 0);
    wait_empty(50);

    // Random backpressure during drain
    push_line(50, LW);
    fork
      feed(50, LW, -1);
      begin
        for (int i = 0; i < 40; i++) begin
          @(posedge clk); #1;
          pix_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    pix_ready = 1'b1;
    wait_empty(100);
    chk("t3_ovf_sticky", overflow, 1);

    // line_start with a coincident sample after 5 writes
    push_line(69, LW);
    feed(60, 17, 5);
    wait_empty(100);

    // Reset in the middle of a drain
    push_line(80, LW);
    base = xfers;
    feed(80, LW, -1);
    wait_xfers(base + 3, 50);
    #1 reset = 1'b0;
    #1;
    chk("mid_rst_valid", pix_valid, 0);
    chk("mid_rst_pix", pix_out, 0);
    chk("mid_rst_last", line_last, 0);
    chk("mid_rst_ovf", overflow, 0);
    q.delete();
    repeat (2) @(negedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    pulse_ls();
    push_line(93, LW);
    feed(90, 11, -1);
    check_latency("t5");
    wait_empty(100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/smooth_line_capture.md
SMOOTH_LINE_CAPTURE -- requirements
Module: smooth_line_capture

Interface
REQ-001: Parameter LINE_W, default 64, pixels per captured line (power of two, 4 to 1024).
REQ-002: Parameter WARMUP, default 3, qualified samples discarded after each line start while the 4-tap average fills.
REQ-003: clk  input  1  single clock; all logic on posedge clk.
REQ-004: reset  input  1  asynchronous, active-low reset.
REQ-005: enb  input  1  sample strobe, the same enable that drives the upstream smoothing filter.
REQ-006: smoothed_in  input  8  smoothing filter output, valid one cycle after its enb.
REQ-007: line_start  input  1  single-cycle pulse that resynchronises the writer to the start of a new line.
REQ-008: pix_out  output  8  drained pixel.
REQ-009: pix_valid  output  1  pix_out holds a valid pixel.
REQ-010: pix_ready  input  1  downstream accepts pix_out.
REQ-011: line_last  output  1  pix_out is column LINE_W-1 of a line; qualified by pix_valid.
REQ-012: overflow  output  1  sticky flag: a sample was dropped because both banks were full.

Function
REQ-013: The block SHALL register enb into enb_d and treat smoothed_in as a qualified sample on cycles where enb_d=1.
REQ-014: After reset or line_start, the first WARMUP qualified samples SHALL be discarded, using a saturating counter.
REQ-015: Each subsequent qualified sample SHALL be written to the current write bank at column wr_col, and wr_col SHALL then increment.
REQ-016: The block SHALL hold two line banks (ping-pong), each LINE_W x 8, and each bank SHALL be in one of three states: EMPTY, FILLING or FULL.
REQ-017: When column LINE_W-1 is written, the bank SHALL go FULL, wr_col SHALL wrap to 0, and the write bank SHALL toggle; the warm-up count SHALL NOT restart.
REQ-018: A qualified sample that arrives while the write bank is FULL SHALL be dropped, overflow SHALL be set, and wr_col SHALL be held.
REQ-019: line_start SHALL zero wr_col and the warm-up count and discard any partial (FILLING) contents; FULL banks SHALL be kept.
REQ-020: If line_start and a qualified sample occur in the same cycle, line_start SHALL win and the sample SHALL be discarded.
REQ-021: While the read bank is FULL, the reader SHALL drain columns 0..LINE_W-1 in order, and a pixel transfer SHALL occur only when pix_valid=1 and pix_ready=1.
REQ-022: pix_out and line_last SHALL stay stable while pix_valid=1 and pix_ready=0.
REQ-023: pix_valid SHALL first rise 2 cycles after the edge that writes the last pixel of a line into an EMPTY read path.
REQ-024: With pix_ready held at 1, the block SHALL output one pixel per cycle with no bubbles within a line and none between back-to-back FULL banks.
REQ-025: After the line_last transfer, the read bank SHALL become EMPTY in that same edge and the read bank SHALL toggle.
REQ-026: If a bank goes FULL and another bank empties in the same cycle, both updates SHALL take effect.
REQ-027: A sample arriving in the same cycle that the write bank frees SHALL still be dropped, so the full check uses registered state.
REQ-028: RAM reads SHALL be synchronous with 1-cycle latency, and a skid/output register SHALL satisfy REQ-022 and REQ-024.

Reset
REQ-029: On reset, the block SHALL take these values asynchronously: pix_out=0, pix_valid=0, line_last=0, overflow=0, enb_d=0, wr_col=0, read column=0, warm-up count=0, both banks EMPTY, write bank=0, read bank=0.
REQ-030: Reset SHALL NOT clear RAM contents, and reset mid-line SHALL abandon all buffered data.
REQ-031: overflow SHALL clear only on reset.

Structure
REQ-032: A shared package SHALL hold the bank-state encoding (EMPTY/FILLING/FULL), the pixel width constant (8), and the LINE_W/WARMUP defaults.
REQ-033: One sub-module, line_bank_ram, SHALL implement a simple dual-port RAM (1 write port, 1 registered read port) and be instantiated twice.

Verification
REQ-034: With LINE_W=8, WARMUP=3, drive reset, then line_start, then enb for 11 cycles with smoothed_in=0..10 (one cycle late) -> values 3..10 drained in order; line_last on value 10; pix_valid rises 2 cycles after value 10 is written.
REQ-035: Feed three full lines with pix_ready=0 -> lines 1 and 2 are kept, the 3rd line's samples are dropped, and overflow=1; then set pix_ready=1 -> 16 contiguous pixels with no bubbles.
REQ-036: Toggle pix_ready randomly during a drain -> pix_out and line_last hold while stalled, and no pixel is lost or duplicated.
REQ-037: Pulse line_start after 5 written samples, together with a qualified sample -> the partial line is discarded, that sample is dropped, and warm-up restarts (next 3 samples discarded).
REQ-038: Assert reset mid-drain -> all outputs immediately 0, and the next line starts cleanly in bank 0.
